edge_event_queue: RTL

EDGE_EVENT_QUEUE -- requirements
Module: edge_event_queue

---
 rtl/edge_event_queue.sv | 101 ++++++++++
 1 files changed

// File: rtl/edge_event_queue.sv
// Timestamped FIFO of one-hot edge events: each pulse is queued as {ts_now, bit index}
// and handed out through a valid/ready head, with sticky drop/multi-bit status.
module edge_event_queue #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned TS_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         in_pulse,
  input  logic                     clr,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic [$clog2(WIDTH)-1:0] evt_idx,
  output logic [TS_W-1:0]          evt_ts,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [7:0]               drop_cnt,
  output logic                     multi_err
);
  localparam int unsigned IDX_W = $clog2(WIDTH);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [TS_W-1:0]  ts_now;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [IDX_W-1:0] mem_idx [DEPTH];
  logic [TS_W-1:0]  mem_ts  [DEPTH];

  logic             event_c;
  logic             multi_c;
  logic             pop_c;
  logic             push_c;
  logic             drop_c;
  logic [IDX_W-1:0] idx_c;
  logic [LVL_W-1:0] level_nxt_c;

  // Lowest set bit wins: scanning downward lets lower bits overwrite higher ones.
  always_comb begin
    idx_c = '0;
    for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
      if (in_pulse[i]) idx_c = IDX_W'(i);
    end
  end

  always_comb begin
    event_c     = |in_pulse;
    multi_c     = |(in_pulse & (in_pulse - WIDTH'(1)));
    pop_c       = evt_valid & evt_ready;
    push_c      = event_c & ((level != LVL_W'(DEPTH)) | pop_c);
    drop_c      = event_c & ~push_c;
    level_nxt_c = level + LVL_W'(push_c) - LVL_W'(pop_c);
  end

  // Pointers, occupancy and timestamp; evt_valid is kept as a flop mirroring level != 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ts_now    <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      evt_valid <= 1'b0;
    end else begin
      ts_now    <= ts_now + TS_W'(1);
      level     <= level_nxt_c;
      evt_valid <= (level_nxt_c != '0);
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Storage needs no reset: pointers and level define which entries are live.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem_idx[wr_ptr] <= idx_c;
      mem_ts[wr_ptr]  <= ts_now;
    end
  end

  assign evt_idx = mem_idx[rd_ptr];
  assign evt_ts  = mem_ts[rd_ptr];

  // Sticky status; an event at the clearing edge still registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow  <= 1'b0;
      multi_err <= 1'b0;
      drop_cnt  <= '0;
    end else if (clr) begin
      overflow  <= drop_c;
      multi_err <= multi_c;
      drop_cnt  <= 8'(drop_c);
    end else begin
      overflow  <= overflow | drop_c;
      multi_err <= multi_err | multi_c;
      if (drop_c && drop_cnt != 8'd255) drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule
